fibonacci_index: RTL and testbench
==================================

FIBONACCI_INDEX -- requirements
Module: fibonacci_index

Interface
REQ-001 Parameter: WIDTH, default 8, bit width of the value input and the index output.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request a search; sampled only in IDLE.
REQ-005 value  input  WIDTH  unsigned candidate; latched on the edge that accepts start.
REQ-006 busy  output  1  high in SEARCH and DONE.
REQ-007 done  output  1  one-cycle completion pulse.
REQ-008 is_fib  output  1  1 if the latched value is a Fibonacci number.
REQ-009 index  output  WIDTH  matching Fibonacci index, or the index of the largest Fibonacci number below value.

Function
REQ-010 Sequence definition: F(0)=0, F(1)=1, F(i)=F(i-1)+F(i-2).
REQ-011 States: IDLE, SEARCH, DONE; encoding is implementation choice.
REQ-012 IDLE with start=1 at an edge: latch value; load a=0, b=1, idx=0; go to SEARCH.
REQ-013 SEARCH, each edge: a==value -> DONE, is_fib=1, index=idx.
REQ-014 SEARCH, a>value -> DONE, is_fib=0, index=idx-1.
REQ-015 SEARCH, otherwise -> a<=b, b<=a+b, idx<=idx+1, stay in SEARCH.
REQ-016 Internal a/b registers WIDTH+2 bits so no wrap occurs before termination; idx is WIDTH bits.
REQ-017 Value 1 reports the smallest matching index (index=1).
REQ-018 DONE lasts exactly one cycle, done=(state==DONE), then returns to IDLE.
REQ-019 Latency: done rises k+1 edges after the edge that sampled start, where k is the final idx.
REQ-020 is_fib/index update only on the SEARCH->DONE edge and hold until the next completion.
REQ-021 start is ignored while busy=1, including in the DONE cycle; no queuing.
REQ-022 value changes after acceptance do not affect the running search.

Reset
REQ-023 rst=0 forces immediately, without a clock: state=IDLE, busy=0, done=0, is_fib=0, index=0, internal registers cleared.
REQ-024 Reset mid-search abandons the search with no done pulse; operation resumes on the first start after rst=1.

Configuration
REQ-025 Macro FIB_IDX_ABORT_EN defined: adds 1-bit input abort.
REQ-026 With FIB_IDX_ABORT_EN, abort=1 in SEARCH -> IDLE at the next edge, no done pulse, is_fib=0, index=0.
REQ-027 With FIB_IDX_ABORT_EN, abort is ignored in IDLE and DONE.
REQ-028 FIB_IDX_ABORT_EN undefined: abort port and logic are absent; behaviour per REQ-010..REQ-024.

Verification
REQ-029 Bench covers, WIDTH=8: start, value=0 -> done 1 edge later, is_fib=1, index=0.
REQ-030 Bench covers, WIDTH=8: start, value=13 -> done 8 edges later, is_fib=1, index=7.
REQ-031 Bench covers, WIDTH=8: start, value=4 -> done 6 edges later, is_fib=0, index=4.
REQ-032 Bench covers, WIDTH=8: start, value=255 -> done 15 edges later, is_fib=0, index=13 (F(13)=233).
REQ-033 Bench covers: start pulsed again while busy and during DONE -> ignored, exactly one done pulse per accepted start.
REQ-034 Bench covers: rst=0 asynchronously mid-search on value=233 -> outputs cleared at once, no done; new start on value=1 -> is_fib=1, index=1.

Source files
------------

// File: rtl/fibonacci_index.sv
// Fibonacci index search: walks F(0), F(1), ... until it reaches or passes the
// latched value, then reports whether the value is a Fibonacci number and the
// matching index, or the index of the largest Fibonacci number below it.
// Optional feature macro: FIB_IDX_ABORT_EN adds an 'abort' input that cancels
// a running search.
module fibonacci_index #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
`ifdef FIB_IDX_ABORT_EN
    input  logic             abort,
`endif
    input  logic [WIDTH-1:0] value,
    output logic             busy,
    output logic             done,
    output logic             is_fib,
    output logic [WIDTH-1:0] index
);

    // Two spare bits keep a/b from wrapping before a passes any WIDTH-bit value.
    localparam int unsigned AW = WIDTH + 2;

    typedef enum logic [1:0] {
        StIdle,
        StSearch,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  value_q, value_d;
    logic [AW-1:0]     a_q, a_d;
    logic [AW-1:0]     b_q, b_d;
    logic [WIDTH-1:0]  idx_q, idx_d;
    logic              is_fib_q, is_fib_d;
    logic [WIDTH-1:0]  index_q, index_d;

    logic [AW-1:0]     value_ext;

    assign value_ext = {2'b00, value_q};

    // Next-state and datapath update; everything holds by default.
    always_comb begin
        state_d  = state_q;
        value_d  = value_q;
        a_d      = a_q;
        b_d      = b_q;
        idx_d    = idx_q;
        is_fib_d = is_fib_q;
        index_d  = index_q;

        case (state_q)
            StIdle: begin
                if (start) begin
                    value_d = value;
                    a_d     = '0;
                    b_d     = {{(AW-1){1'b0}}, 1'b1};
                    idx_d   = '0;
                    state_d = StSearch;
                end
            end
            StSearch: begin
`ifdef FIB_IDX_ABORT_EN
                if (abort) begin
                    is_fib_d = 1'b0;
                    index_d  = '0;
                    state_d  = StIdle;
                end else
`endif
                if (a_q == value_ext) begin
                    is_fib_d = 1'b1;
                    index_d  = idx_q;
                    state_d  = StDone;
                end else if (a_q > value_ext) begin
                    // a starts at 0, so it can only overshoot once idx >= 1.
                    is_fib_d = 1'b0;
                    index_d  = idx_q - {{(WIDTH-1){1'b0}}, 1'b1};
                    state_d  = StDone;
                end else begin
                    a_d   = b_q;
                    b_d   = a_q + b_q;
                    idx_d = idx_q + {{(WIDTH-1){1'b0}}, 1'b1};
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            value_q  <= '0;
            a_q      <= '0;
            b_q      <= '0;
            idx_q    <= '0;
            is_fib_q <= 1'b0;
            index_q  <= '0;
        end else begin
            state_q  <= state_d;
            value_q  <= value_d;
            a_q      <= a_d;
            b_q      <= b_d;
            idx_q    <= idx_d;
            is_fib_q <= is_fib_d;
            index_q  <= index_d;
        end
    end

    // Status outputs decoded from the state register.
    always_comb begin
        busy   = (state_q != StIdle);
        done   = (state_q == StDone);
        is_fib = is_fib_q;
        index  = index_q;
    end

endmodule

// File: tb/tb_fibonacci_index.sv
// Scoreboard bench for fibonacci_index (WIDTH=8): stimulus pushes expected
// results, a negedge monitor pops and compares on every done pulse.
module tb_fibonacci_index;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] value;
    logic       busy;
    logic       done;
    logic       is_fib;
    logic [7:0] index;
`ifdef FIB_IDX_ABORT_EN
    logic       abort;
    initial abort = 1'b0;
`endif

    fibonacci_index #(.WIDTH(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
`ifdef FIB_IDX_ABORT_EN
        .abort  (abort),
`endif
        .value  (value),
        .busy   (busy),
        .done   (done),
        .is_fib (is_fib),
        .index  (index)
    );

    typedef struct {
        logic       is_fib;
        logic [7:0] index;
        int         done_cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   n_done = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Rising-edge counter used to measure latency.
    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks = checks + 1;
        if (act != req) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: every done pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (rst && done) begin
            n_done = n_done + 1;
            if (exp_q.size() == 0) begin
                checks = checks + 1;
                errors = errors + 1;
                $display("FAIL spurious_done: got done=1 expected no pulse (cyc=%0d)", cyc);
            end else begin
                e = exp_q.pop_front();
                check("is_fib", int'(is_fib), int'(e.is_fib));
                check("index", int'(index), int'(e.index));
                check("latency_edge", cyc, e.done_cyc);
            end
        end
    end

    // Issue one accepted start at a negedge; value changes right after acceptance.
    task automatic issue(input logic [7:0] v, input logic f, input int idx, input int lat);
        exp_t x;
        x.is_fib   = f;
        x.index    = 8'(idx);
        x.done_cyc = cyc + 1 + lat;
        exp_q.push_back(x);
        start = 1'b1;
        value = v;
        @(negedge clk);
        start = 1'b0;
        value = 8'hAA;
    endtask

    // Wait (bounded) until all expectations are consumed, then let DONE retire.
    task automatic drain();
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic check_hold(input string name, input logic f, input int idx);
        repeat (3) @(negedge clk);
        check({name, "_busy_idle"}, int'(busy), 0);
        check({name, "_is_fib_hold"}, int'(is_fib), int'(f));
        check({name, "_index_hold"}, int'(index), idx);
    endtask

    initial begin
        rst   = 1'b0;
        start = 1'b0;
        value = 8'h00;
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_is_fib", int'(is_fib), 0);
        check("rst_index", int'(index), 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // value=0: F(0), one edge.
        issue(8'd0, 1'b1, 0, 1);
        drain();
        check_hold("v0", 1'b1, 0);

        // value=13: F(7), eight edges.
        issue(8'd13, 1'b1, 7, 8);
        check("v13_busy", int'(busy), 1);
        drain();
        check_hold("v13", 1'b1, 7);

        // value=4: between F(4)=3 and F(5)=5.
        issue(8'd4, 1'b0, 4, 6);
        drain();
        check_hold("v4", 1'b0, 4);

        // value=255: largest below is F(13)=233.
        issue(8'd255, 1'b0, 13, 15);
        drain();
        check_hold("v255", 1'b0, 13);

        // start held high through SEARCH and DONE: only the first is accepted.
        issue(8'd13, 1'b1, 7, 8);
        start = 1'b1;
        value = 8'd4;
        repeat (9) @(negedge clk);
        check("busy_ignore_busy", int'(busy), 0);
        start = 1'b0;
        drain();
        repeat (20) @(negedge clk);
        check("busy_ignore_idle", int'(busy), 0);
        check("busy_ignore_is_fib", int'(is_fib), 1);
        check("busy_ignore_index", int'(index), 7);

        // Asynchronous reset in the middle of a search on 233.
        start = 1'b1;
        value = 8'd233;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        check("mid_search_busy", int'(busy), 1);
        #2;
        rst = 1'b0;
        #1;
        check("async_busy", int'(busy), 0);
        check("async_done", int'(done), 0);
        check("async_is_fib", int'(is_fib), 0);
        check("async_index", int'(index), 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        check("after_rst_busy", int'(busy), 0);

        // Value 1 reports the smallest index.
        issue(8'd1, 1'b1, 1, 2);
        drain();
        check_hold("v1", 1'b1, 1);

        check("done_pulse_count", n_done, 6);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
